// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM data-memory controller.
// The byte-merge helper builds the write word for partial stores.
package sram_ctrl_pkg;

  localparam int WORD_W      = 32;
  localparam int BYTE_LANES  = 4;
  localparam int MACRO_DEPTH = 64;
  localparam int ROW_W       = 6;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RMW,
    ACK
  } state_e;

  // Enabled lanes take the store data; the other lanes keep the old memory data.
  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [BYTE_LANES-1:0] be,
    input logic [WORD_W-1:0]     wdata,
    input logic [WORD_W-1:0]     rdata
  );
    logic [WORD_W-1:0] merged;
    merged = rdata;
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/SRAM_32x64_1rw.sv
// Behavioural stand-in for the 32x64 single-port SRAM macro.
// Both reads and writes are synchronous; dout0 holds its value between reads.
module SRAM_32x64_1rw (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [5:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0
);

  logic [31:0] mem [0:63];

  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) mem[addr0] <= din0;
      else       dout0      <= mem[addr0];
    end
  end

endmodule

// File: rtl/sram_bank_array.sv
// NUM_BANKS SRAM macros sharing address, data and write-enable lines.
// Only the addressed bank is selected; read data is steered by the bank read last.
module sram_bank_array
  import sram_ctrl_pkg::*;
#(
  parameter  int NUM_BANKS = 2,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic [BANK_W-1:0] bank,
  input  logic [ROW_W-1:0]  row,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  logic [NUM_BANKS-1:0] bank_csb;
  logic [WORD_W-1:0]    bank_dout [NUM_BANKS];
  logic [BANK_W-1:0]    rd_bank_reg;

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      assign bank_csb[gi] = !(cs && (bank == BANK_W'(gi)));

      SRAM_32x64_1rw u_macro (
        .clk0  (clk),
        .csb0  (bank_csb[gi]),
        .web0  (!we),
        .addr0 (row),
        .din0  (din),
        .dout0 (bank_dout[gi])
      );
    end
  endgenerate

  // Macro output appears a cycle after the read, so remember which bank was read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         rd_bank_reg <= '0;
    else if (cs && !we) rd_bank_reg <= bank;
  end

  assign dout = bank_dout[rd_bank_reg];

endmodule

// File: rtl/sram_dmem_ctrl.sv
// Load/store front end for the banked data SRAM: valid/ready requests,
// one-cycle response pulse, byte-enabled stores via read-modify-write.
module sram_dmem_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int          NUM_BANKS = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [31:0] SPAN   = 32'(MACRO_DEPTH * NUM_BANKS * BYTE_LANES);

  state_e                  state_reg, state_next;
  logic [BANK_W-1:0]       bank_reg, dec_bank, mem_bank;
  logic [ROW_W-1:0]        row_reg, dec_row, mem_row;
  logic [BYTE_LANES-1:0]   be_reg;
  logic [WORD_W-1:0]       wdata_reg, mem_din, mem_dout;
  logic [31:0]             off;
  logic                    err_reg, dec_err, accept, mem_cs, mem_we;

  assign off     = req_addr - BASE_ADDR;
  assign dec_err = (req_addr < BASE_ADDR) || (off >= SPAN);
  assign dec_row = off[2 +: ROW_W];

  generate
    if (NUM_BANKS > 1) begin : g_multi_bank
      assign dec_bank = off[2+ROW_W +: BANK_W];
    end else begin : g_single_bank
      assign dec_bank = '0;
    end
  endgenerate

  // Held low throughout reset so nothing is accepted before the FSM is running.
  assign req_ready = (state_reg == IDLE) && reset;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      bank_reg  <= '0;
      row_reg   <= '0;
      be_reg    <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        bank_reg  <= dec_bank;
        row_reg   <= dec_row;
        be_reg    <= req_be;
        wdata_reg <= req_wdata;
        err_reg   <= dec_err;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_bank   = bank_reg;
    mem_row    = row_reg;
    mem_din    = req_wdata;
    rsp_valid  = 1'b0;
    rsp_rdata  = '0;
    rsp_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          mem_bank = dec_bank;
          mem_row  = dec_row;
          if (dec_err) begin
            state_next = ACK;
          end else if (!req_we) begin
            mem_cs     = 1'b1;
            state_next = RD_WAIT;
          end else if (req_be == 4'hF) begin
            mem_cs     = 1'b1;
            mem_we     = 1'b1;
            state_next = ACK;
          end else if (req_be == 4'h0) begin
            state_next = ACK;
          end else begin
            mem_cs     = 1'b1;
            state_next = RMW;
          end
        end
      end
      RD_WAIT: begin
        rsp_valid  = 1'b1;
        rsp_rdata  = mem_dout;
        state_next = IDLE;
      end
      RMW: begin
        mem_cs     = 1'b1;
        mem_we     = 1'b1;
        mem_din    = merge_bytes(be_reg, wdata_reg, mem_dout);
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      ACK: begin
        rsp_valid  = 1'b1;
        rsp_err    = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  sram_bank_array #(
    .NUM_BANKS (NUM_BANKS)
  ) u_banks (
    .clk   (clk),
    .reset (reset),
    .cs    (mem_cs),
    .we    (mem_we),
    .bank  (mem_bank),
    .row   (mem_row),
    .din   (mem_din),
    .dout  (mem_dout)
  );

endmodule

// File: doc/sram_dmem_ctrl.md
Name: sram_dmem_ctrl

Overview:
Parametrised data-memory controller between the pipelined MIPS core's load/store port and a bank of SRAM_32x64_1rw macros (synchronous read, one read/write port, no byte mask). Adds a valid/ready request handshake and a one-cycle response channel that absorbs the SRAM read latency. Supports byte-enabled writes via internal read-modify-write, multiple banks, a configurable base address, and out-of-range error reporting. Replaces direct macro hookup on the data side; the core stalls on req_ready.

Parameters:
NUM_BANKS, 2, number of 64x32 macros; power of two, 1..8; capacity = 64*NUM_BANKS words
BASE_ADDR, 32'h0000_0000, byte address of word 0; 256*NUM_BANKS-aligned

Ports:
clk  in  1  single clock; macros on same clock
reset  in  1  asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept; transfer when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_be  in  4  byte enables for store, bit i = byte lane i; ignored on load
req_addr  in  32  byte address; bits [1:0] ignored
req_wdata  in  32  store data, lane-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load data, valid with rsp_valid on loads; 0 otherwise
rsp_err  out  1  address out of range, valid with rsp_valid

Behaviour:
- Reset (reset low, async): state IDLE; rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready=0 while reset low, 1 in first cycle after release. Captured bank/row/be/wdata registers cleared.
- Decode: off = req_addr - BASE_ADDR; idx = off[31:2]; bank = idx[6 +: log2(NUM_BANKS)]; row = idx[5:0]. Out of range if req_addr < BASE_ADDR or idx >= 64*NUM_BANKS.
- Macro control: only selected bank gets csb0=0 in the issuing cycle; all other banks csb0=1. web0=0 only for write cycles. din0 shared.
- FSM states: IDLE, RD_WAIT, RMW, ACK. req_ready = (state==IDLE).
- IDLE, accept, out of range: no macro access -> ACK with rsp_err=1.
- IDLE, accept load: issue read to bank/row -> RD_WAIT.
- IDLE, accept store, be==4'hF: issue write of req_wdata -> ACK.
- IDLE, accept store, be==4'h0: no macro access -> ACK.
- IDLE, accept store, partial be: issue read -> RMW.
- RD_WAIT: rsp_valid=1, rsp_rdata = dout0 of captured bank -> IDLE.
- RMW: merged byte i = be[i] ? wdata byte i : dout0 byte i; issue write of merged word to captured bank/row; rsp_valid=1 -> IDLE.
- ACK: rsp_valid=1 (rsp_err as decoded) -> IDLE.
- Latency: every accepted request gets exactly one rsp_valid pulse in the cycle after acceptance. Max throughput one request per 2 cycles. Responses in request order, no overlap.
- req_* need only be stable in the accept cycle; all later use of them comes from captured registers.
- Reset asserted in RD_WAIT/RMW/ACK: immediate IDLE, no response. A pending RMW write is dropped and memory is unchanged. A write already clocked into a macro persists.
- req_valid with req_ready=0: ignored; the core must hold it.

Decomposition:
- Package sram_ctrl_pkg: state enum (IDLE, RD_WAIT, RMW, ACK), WORD_W=32, BYTE_LANES=4, MACRO_DEPTH=64, ROW_W=6, byte-merge function.
- Sub-module sram_bank_array: generate of NUM_BANKS SRAM_32x64_1rw instances with per-bank csb0 decode, shared addr0/din0/web0, and registered-bank-index dout mux.

Test Plan:
- Full store 0x44 <- 0xDEADBEEF, be=F; load 0x44 -> rsp_valid one cycle after accept, rsp_rdata=0xDEADBEEF, rsp_err=0; req_ready low exactly one cycle per request.
- Partial store 0x44, be=4'b0010, wdata=0x0000AA00 after the above -> ack one cycle later; load 0x44 returns 0xDEADAAEF; only bank0 csb0 ever low.
- Bank boundary: store 0xFC <- 0x11111111 and 0x100 <- 0x22222222; loads return each value unchanged; 0x100 activates bank1 row 0 only.
- Out of range: load 0x200 (NUM_BANKS=2) -> rsp_err=1, rsp_rdata=0, no csb0 low on any bank.
- Reset low during RMW of store 0x44 be=4'b0001 wdata=0xFF -> rsp_valid never pulses, later load returns 0xDEADAAEF, req_ready=1 first cycle after release.
- Store be=0 to 0x44, then back-to-back req_valid held high for 4 loads -> ack with no write; 4 loads accepted on alternating cycles, each with a correct rsp_valid pulse.
